// File: rtl/dm_pkg.sv
// Shared constants for the debug-module OBI front-end.
// The response entry layout depends on bridge parameters and lives in the bridge itself.
package dm_pkg;

    localparam int unsigned DmObiBaseAddress = 32'h0000_1000;
    localparam int unsigned DmObiWindowSize  = 32'h0000_1000;

endpackage

// File: rtl/dm_obi_rsp_fifo.sv
// Parametrised synchronous FIFO for buffered OBI responses.
// Pointers wrap modulo Depth, so non power-of-two depths are legal.
module dm_obi_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] cnt
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  rptr_r;
    logic [PtrW-1:0]  wptr_r;
    logic [CntW-1:0]  cnt_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == LastPtr) begin
            return {PtrW{1'b0}};
        end else begin
            return p + {{(PtrW-1){1'b0}}, 1'b1};
        end
    endfunction

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= {Width{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r <= {PtrW{1'b0}};
            wptr_r <= {PtrW{1'b0}};
            cnt_r  <= {CntW{1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (do_pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                2'b01:   cnt_r <= cnt_r - {{(CntW-1){1'b0}}, 1'b1};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign full  = (cnt_r == FullCnt);
    assign empty = (cnt_r == {CntW{1'b0}});
    assign head  = mem_r[rptr_r];
    assign cnt   = cnt_r;

endmodule

// File: rtl/dm_obi_slave_bridge.sv
// OBI slave front-end for the debug module: window check, response buffering with
// rready backpressure, aid->rid mirroring and a 1-cycle fall-through read path.
module dm_obi_slave_bridge
    import dm_pkg::*;
#(
    parameter int unsigned IdWidth       = 1,
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned RspDepth      = 2,
    parameter bit          UseRReady     = 1'b1,
    parameter int unsigned DmBaseAddress = DmObiBaseAddress,
    parameter int unsigned DmWindowSize  = DmObiWindowSize
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    output logic                  slave_gnt_o,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_addr_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [IdWidth-1:0]    slave_aid_i,
    output logic                  slave_rvalid_o,
    input  logic                  slave_rready_i,
    output logic [BusWidth-1:0]   slave_rdata_o,
    output logic [IdWidth-1:0]    slave_rid_o,
    output logic                  slave_err_o,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [BusWidth-1:0]   dm_addr_o,
    output logic [BusWidth/8-1:0] dm_be_o,
    output logic [BusWidth-1:0]   dm_wdata_o,
    input  logic [BusWidth-1:0]   dm_rdata_i
);

    localparam int unsigned CntW = $clog2(RspDepth + 1);
    localparam int unsigned RspW = BusWidth + IdWidth + 1;
    localparam logic [BusWidth-1:0] WinMask = ~BusWidth'(DmWindowSize - 1);
    localparam logic [BusWidth-1:0] WinBase = BusWidth'(DmBaseAddress);
    localparam logic [CntW:0]       DepthC  = (CntW + 1)'(RspDepth);

    typedef struct packed {
        logic [BusWidth-1:0] rdata;
        logic [IdWidth-1:0]  rid;
        logic                err;
    } rsp_t;

    logic               active_r;
    logic               pend_r;
    logic [IdWidth-1:0] pend_rid_r;
    logic               pend_err_r;
    logic               pend_we_r;

    logic               in_win_s;
    logic               gnt_s;
    logic               accept_s;
    logic               rready_eff_s;
    logic [CntW:0]      credit_s;
    logic               rvalid_s;
    logic               push_s;
    logic               pop_s;
    rsp_t               pend_rsp_s;
    rsp_t               out_rsp_s;
    logic [RspW-1:0]    fifo_head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CntW-1:0]    fifo_cnt_s;

    assign in_win_s     = ((slave_addr_i & WinMask) == WinBase);
    assign rready_eff_s = UseRReady ? slave_rready_i : 1'b1;
    assign credit_s     = {1'b0, fifo_cnt_s} + {{CntW{1'b0}}, pend_r};

    // Grant credit: only registered state feeds gnt, so rready never reaches it combinationally
    always_comb begin
        gnt_s = 1'b0;
        if (!active_r) begin
            gnt_s = 1'b0;
        end else if (UseRReady) begin
            gnt_s = ~fifo_full_s & (credit_s < DepthC);
        end else begin
            gnt_s = 1'b1;
        end
    end

    assign accept_s    = slave_req_i & gnt_s;
    assign slave_gnt_o = gnt_s;
    assign dm_req_o    = accept_s & in_win_s;
    assign dm_we_o     = slave_we_i;
    assign dm_addr_o   = slave_addr_i;
    assign dm_be_o     = slave_be_i;
    assign dm_wdata_o  = slave_wdata_i;

    // Holds grant low for the first cycle after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_r <= 1'b0;
        end else begin
            active_r <= 1'b1;
        end
    end

    // Pending response captured at acceptance; its data arrives from dm_top one cycle later
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_r     <= 1'b0;
            pend_rid_r <= {IdWidth{1'b0}};
            pend_err_r <= 1'b0;
            pend_we_r  <= 1'b0;
        end else if (accept_s) begin
            pend_r     <= 1'b1;
            pend_rid_r <= slave_aid_i;
            pend_err_r <= ~in_win_s;
            pend_we_r  <= slave_we_i;
        end else begin
            pend_r     <= 1'b0;
        end
    end

    // Build the pending entry; writes and errors never return dm_top data
    always_comb begin
        pend_rsp_s.rid = pend_rid_r;
        pend_rsp_s.err = pend_err_r;
        if (pend_err_r || pend_we_r) begin
            pend_rsp_s.rdata = {BusWidth{1'b0}};
        end else begin
            pend_rsp_s.rdata = dm_rdata_i;
        end
    end

    // Buffered head has priority over the pending entry to keep acceptance order
    always_comb begin
        out_rsp_s = {RspW{1'b0}};
        rvalid_s  = 1'b0;
        if (!fifo_empty_s) begin
            out_rsp_s = fifo_head_s;
            rvalid_s  = 1'b1;
        end else if (pend_r) begin
            out_rsp_s = pend_rsp_s;
            rvalid_s  = 1'b1;
        end else begin
            out_rsp_s = {RspW{1'b0}};
            rvalid_s  = 1'b0;
        end
    end

    assign push_s = pend_r & ~(fifo_empty_s & rready_eff_s);
    assign pop_s  = rvalid_s & rready_eff_s & ~fifo_empty_s;

    dm_obi_rsp_fifo #(
        .Depth (RspDepth),
        .Width (RspW)
    ) u_rsp_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_s),
        .wdata (pend_rsp_s),
        .pop   (pop_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .cnt   (fifo_cnt_s)
    );

    assign slave_rvalid_o = rvalid_s;
    assign slave_rdata_o  = out_rsp_s.rdata;
    assign slave_rid_o    = out_rsp_s.rid;
    assign slave_err_o    = out_rsp_s.err;

endmodule
